// File: rtl/nf10_axis_pkt_gen.sv
// nf10_axis_pkt_gen
// AXI4-Stream master that emits deterministic test packets on the 256-bit
// NetFPGA-10G data path. A start pulse in IDLE latches the packet length,
// the packet count and the inter-frame gap, and the run then proceeds with
// no further input except backpressure.
//
// Ports
//   aclk, reset        clock, synchronous active-high reset
//   start              one-cycle run request, honoured only in IDLE
//   pkt_len            packet length in bytes (0 means 64)
//   num_pkts           packets per run (0 means no run, just clears pkt_count)
//   ifg_cycles         idle cycles between packets
//   busy               high while SEND or GAP
//   pkt_count          packets completed since the last accepted start
//   m_axis_*           AXI4-Stream master (tdata/tstrb/tuser/tvalid/tready/tlast)
//
// Byte lane j of beat b carries (32*b + j) mod 256, which is simply
// {b[2:0], j[4:0]}. tuser carries {dst, src, length} in its low 32 bits.
module nf10_axis_pkt_gen #(
   parameter int         C_M_AXIS_DATA_WIDTH  = 256,
   parameter int         C_M_AXIS_TUSER_WIDTH = 128,
   parameter logic [7:0] C_SRC_PORT           = 8'h01,
   parameter logic [7:0] C_DST_PORT           = 8'h04
) (
   input  logic                              aclk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [15:0]                       pkt_len,
   input  logic [15:0]                       num_pkts,
   input  logic [7:0]                        ifg_cycles,
   output logic                              busy,
   output logic [31:0]                       pkt_count,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast
);

   localparam int STRB_W = C_M_AXIS_DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t      state;
   logic [15:0] len_q;
   logic [15:0] rem_q;
   logic [7:0]  ifg_q;
   logic [7:0]  gap_cnt;
   logic [10:0] beat;

   function automatic logic [15:0] eff_len(input logic [15:0] l);
      return (l == 16'd0) ? 16'd64 : l;
   endfunction

   // Index of the last beat, (L-1) >> 5; 11 bits cover L up to 65535.
   function automatic logic [10:0] last_beat(input logic [15:0] l);
      logic [15:0] m;
      m = eff_len(l) - 16'd1;
      return m[15:5];
   endfunction

   function automatic logic [C_M_AXIS_DATA_WIDTH-1:0] beat_data(input logic [10:0] b);
      logic [C_M_AXIS_DATA_WIDTH-1:0] d;
      d = '0;
      for (int j = 0; j < STRB_W; j++)
         d[8*j +: 8] = {b[2:0], 5'(j)};
      return d;
   endfunction

   function automatic logic [STRB_W-1:0] beat_strb(input logic [10:0] b,
                                                   input logic [15:0] l);
      logic [STRB_W-1:0] s;
      logic [15:0]       e;
      e = eff_len(l);
      s = '1;
      // Partial last beat keeps only the low (L mod 32) lanes.
      if (b == last_beat(l) && e[4:0] != 5'd0)
         s = ~(s << e[4:0]);
      return s;
   endfunction

   function automatic logic [C_M_AXIS_TUSER_WIDTH-1:0] beat_user(input logic [15:0] l);
      logic [C_M_AXIS_TUSER_WIDTH-1:0] u;
      u        = '0;
      u[15:0]  = eff_len(l);
      u[23:16] = C_SRC_PORT;
      u[31:24] = C_DST_PORT;
      return u;
   endfunction

   // Contents of the beat that would be presented after the next load.
   // In IDLE the length comes straight from the port so the first beat can
   // be registered on the same edge that latches it.
   logic [10:0]                     nxt_beat;
   logic [15:0]                     src_len;
   logic [C_M_AXIS_DATA_WIDTH-1:0]  nxt_data;
   logic [STRB_W-1:0]               nxt_strb;
   logic [C_M_AXIS_TUSER_WIDTH-1:0] nxt_user;
   logic                            nxt_last;

   always_comb begin
      src_len  = (state == IDLE) ? pkt_len : len_q;
      nxt_beat = 11'd0;
      if (state == SEND && !m_axis_tlast)
         nxt_beat = beat + 11'd1;
      nxt_data = beat_data(nxt_beat);
      nxt_strb = beat_strb(nxt_beat, src_len);
      nxt_user = beat_user(src_len);
      nxt_last = (nxt_beat == last_beat(src_len));
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         state         <= IDLE;
         len_q         <= '0;
         rem_q         <= '0;
         ifg_q         <= '0;
         gap_cnt       <= '0;
         beat          <= '0;
         busy          <= 1'b0;
         pkt_count     <= '0;
         m_axis_tdata  <= '0;
         m_axis_tstrb  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  pkt_count <= '0;
                  if (num_pkts != 16'd0) begin
                     len_q         <= pkt_len;
                     rem_q         <= num_pkts;
                     ifg_q         <= ifg_cycles;
                     state         <= SEND;
                     busy          <= 1'b1;
                     beat          <= nxt_beat;
                     m_axis_tvalid <= 1'b1;
                     m_axis_tdata  <= nxt_data;
                     m_axis_tstrb  <= nxt_strb;
                     m_axis_tuser  <= nxt_user;
                     m_axis_tlast  <= nxt_last;
                  end
               end
            end

            SEND: begin
               if (m_axis_tvalid && m_axis_tready) begin
                  if (m_axis_tlast) begin
                     pkt_count <= pkt_count + 32'd1;
                     rem_q     <= rem_q - 16'd1;
                  end
                  if (m_axis_tlast && rem_q == 16'd1) begin
                     state         <= IDLE;
                     busy          <= 1'b0;
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                  end else if (m_axis_tlast && ifg_q != 8'd0) begin
                     state         <= GAP;
                     gap_cnt       <= ifg_q;
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                  end else begin
                     // Next beat, or first beat of the next packet with no bubble.
                     beat         <= nxt_beat;
                     m_axis_tdata <= nxt_data;
                     m_axis_tstrb <= nxt_strb;
                     m_axis_tuser <= nxt_user;
                     m_axis_tlast <= nxt_last;
                  end
               end
            end

            GAP: begin
               // gap_cnt is loaded with ifg, so tvalid is low for ifg cycles.
               if (gap_cnt == 8'd1) begin
                  state         <= SEND;
                  beat          <= nxt_beat;
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= nxt_data;
                  m_axis_tstrb  <= nxt_strb;
                  m_axis_tuser  <= nxt_user;
                  m_axis_tlast  <= nxt_last;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nf10_axis_pkt_gen.sv
module tb_nf10_axis_pkt_gen;

   logic          aclk = 1'b0;
   logic          reset;
   logic          start;
   logic [15:0]   pkt_len;
   logic [15:0]   num_pkts;
   logic [7:0]    ifg_cycles;
   logic          busy;
   logic [31:0]   pkt_count;
   logic [255:0]  m_axis_tdata;
   logic [31:0]   m_axis_tstrb;
   logic [127:0]  m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;

   int n_chk = 0;
   int n_err = 0;

   always #5 aclk = ~aclk;

   nf10_axis_pkt_gen dut (
      .aclk          (aclk),
      .reset         (reset),
      .start         (start),
      .pkt_len       (pkt_len),
      .num_pkts      (num_pkts),
      .ifg_cycles    (ifg_cycles),
      .busy          (busy),
      .pkt_count     (pkt_count),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [255:0] exp_data(input int b);
      logic [255:0] d;
      for (int j = 0; j < 32; j++)
         d[8*j +: 8] = 8'((32*b + j) % 256);
      return d;
   endfunction

   function automatic logic [31:0] exp_strb(input int le, input int b);
      int nb, r;
      nb = (le + 31) / 32;
      r  = le % 32;
      if (b < nb - 1 || r == 0) return 32'hFFFF_FFFF;
      return 32'((64'd1 << r) - 64'd1);
   endfunction

   function automatic logic [127:0] exp_user(input int le);
      return {96'd0, 8'h04, 8'h01, 16'(le)};
   endfunction

   task automatic do_start(input logic [15:0] l, input logic [15:0] n, input logic [7:0] g);
      pkt_len = l; num_pkts = n; ifg_cycles = g; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Runs a full transfer with tready=1 and checks every beat and gap
   // against the model. Control inputs are scrambled right after the start;
   // if poke >= 0 a second start is pulsed on that cycle of the run.
   task automatic check_run(input string tag, input logic [15:0] l, input logic [15:0] n,
                            input logic [7:0] g, input int poke);
      int le, nb, b, pk, gap, cyc;
      le = (l == 16'd0) ? 64 : int'(l);
      nb = (le + 31) / 32;
      m_axis_tready = 1'b1;
      do_start(l, n, g);
      chk({tag, ".lat"}, m_axis_tvalid, 1'b1);
      pkt_len = 16'd32; num_pkts = 16'd9; ifg_cycles = 8'd7;
      b = 0; pk = 0; gap = 0; cyc = 0;
      while (busy && cyc < 2000) begin
         start = (cyc == poke);
         if (m_axis_tvalid) begin
            if (b == 0 && pk > 0) chk({tag, ".gap"}, 256'(gap), 256'(g));
            chk({tag, ".data"}, m_axis_tdata, exp_data(b));
            chk({tag, ".strb"}, m_axis_tstrb, exp_strb(le, b));
            chk({tag, ".user"}, m_axis_tuser, exp_user(le));
            chk({tag, ".last"}, m_axis_tlast, b == nb - 1);
            gap = 0;
            if (b == nb - 1) begin b = 0; pk++; end else b++;
         end else begin
            gap++;
         end
         step();
         cyc++;
      end
      start = 1'b0;
      chk({tag, ".timeout"}, busy, 1'b0);
      chk({tag, ".vld_end"}, m_axis_tvalid, 1'b0);
      chk({tag, ".npkts"}, 256'(pk), 256'(n));
      chk({tag, ".pkt_count"}, pkt_count, 256'(n));
   endtask

   initial begin
      logic [255:0] sd;
      logic [31:0]  ss;
      logic         sl;
      int           hs;
      int           pat [6] = '{1, 0, 0, 1, 0, 1};

      reset = 1'b1; start = 1'b0; pkt_len = '0; num_pkts = '0; ifg_cycles = '0;
      m_axis_tready = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      step();
      chk("rst.tvalid", m_axis_tvalid, 1'b0);
      chk("rst.tlast", m_axis_tlast, 1'b0);
      chk("rst.busy", busy, 1'b0);
      chk("rst.pkt_count", pkt_count, 32'd0);
      chk("rst.tdata", m_axis_tdata, 256'd0);
      chk("rst.tstrb", m_axis_tstrb, 32'd0);
      chk("rst.tuser", m_axis_tuser, 128'd0);

      // Single 64-byte packet, hand-computed values.
      do_start(16'd64, 16'd1, 8'd0);
      chk("p64.b0.vld", m_axis_tvalid, 1'b1);
      chk("p64.b0.busy", busy, 1'b1);
      chk("p64.b0.lane0", m_axis_tdata[7:0], 8'h00);
      chk("p64.b0.lane31", m_axis_tdata[255:248], 8'h1F);
      chk("p64.b0.strb", m_axis_tstrb, 32'hFFFF_FFFF);
      chk("p64.b0.last", m_axis_tlast, 1'b0);
      chk("p64.b0.user", m_axis_tuser[31:0], 32'h0401_0040);
      step();
      chk("p64.b1.vld", m_axis_tvalid, 1'b1);
      chk("p64.b1.lane0", m_axis_tdata[7:0], 8'h20);
      chk("p64.b1.strb", m_axis_tstrb, 32'hFFFF_FFFF);
      chk("p64.b1.last", m_axis_tlast, 1'b1);
      step();
      chk("p64.end.vld", m_axis_tvalid, 1'b0);
      chk("p64.end.busy", busy, 1'b0);
      chk("p64.end.cnt", pkt_count, 32'd1);

      // Odd length: last beat of 65 bytes, hand-computed.
      do_start(16'd65, 16'd1, 8'd0);
      step(); step();
      chk("p65.b2.last", m_axis_tlast, 1'b1);
      chk("p65.b2.strb", m_axis_tstrb, 32'h0000_0001);
      chk("p65.b2.lane0", m_axis_tdata[7:0], 8'h40);
      step();
      chk("p65.end.vld", m_axis_tvalid, 1'b0);

      check_run("l65", 16'd65, 16'd1, 8'd0, -1);
      check_run("l0", 16'd0, 16'd1, 8'd0, -1);

      // Backpressure: L=96, tready 1,0,0,1,0,1.
      do_start(16'd96, 16'd1, 8'd0);
      hs = 0;
      for (int k = 0; k < 6; k++) begin
         m_axis_tready = pat[k][0];
         sd = m_axis_tdata; ss = m_axis_tstrb; sl = m_axis_tlast;
         if (m_axis_tvalid && m_axis_tready) begin
            chk("bp.data", m_axis_tdata, exp_data(hs));
            chk("bp.last", m_axis_tlast, hs == 2);
            hs++;
         end
         step();
         if (pat[k] == 0) begin
            chk("bp.hold.vld", m_axis_tvalid, 1'b1);
            chk("bp.hold.data", m_axis_tdata, sd);
            chk("bp.hold.strb", m_axis_tstrb, ss);
            chk("bp.hold.last", m_axis_tlast, sl);
         end
      end
      m_axis_tready = 1'b1;
      chk("bp.hs", 256'(hs), 256'd3);
      chk("bp.end.vld", m_axis_tvalid, 1'b0);
      chk("bp.end.cnt", pkt_count, 32'd1);

      // Multi-packet with and without gaps.
      check_run("ifg2", 16'd32, 16'd3, 8'd2, -1);
      check_run("ifg0", 16'd32, 16'd3, 8'd0, -1);

      // num_pkts=0: no traffic, pkt_count cleared from the previous 3.
      do_start(16'd64, 16'd0, 8'd0);
      for (int k = 0; k < 3; k++) begin
         chk("n0.vld", m_axis_tvalid, 1'b0);
         chk("n0.busy", busy, 1'b0);
         step();
      end
      chk("n0.cnt", pkt_count, 32'd0);

      // Start pulsed during the gap of a run is ignored.
      check_run("ign", 16'd64, 16'd2, 8'd3, 2);

      // Reset mid-packet, then a clean packet.
      do_start(16'd128, 16'd1, 8'd0);
      step(); step();
      chk("rmid.pre.vld", m_axis_tvalid, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rmid.vld", m_axis_tvalid, 1'b0);
      chk("rmid.last", m_axis_tlast, 1'b0);
      chk("rmid.busy", busy, 1'b0);
      chk("rmid.cnt", pkt_count, 32'd0);
      step();
      check_run("after_rst", 16'd32, 16'd1, 8'd0, -1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
